// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit hex seven-segment scanner with per-digit dp, 16-level PWM and frame-synchronous updates.
// Optional leading-zero blanking is compiled in when SEG7_LZB_EN is defined.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                load,
    input  logic [3:0]          brightness,
    output logic [6:0]          segments,
    output logic                dp,
    output logic [DIGITS-1:0]   digit_sel,
    output logic                frame_done
);

    localparam int PW   = $clog2(PRESCALE);
    localparam int IW   = $clog2(DIGITS);
    localparam int STEP = PRESCALE / 16;

    logic [PW-1:0]       pcnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] stage_val;
    logic [DIGITS-1:0]   stage_dp;
    logic [4*DIGITS-1:0] shadow_val;
    logic [DIGITS-1:0]   shadow_dp;
    logic                pending;
    logic                wrap_d;

    logic                slot_end;
    logic                wrap;
    logic [3:0]          nib;
    logic                dp_bit;
    logic [PW:0]         win_end;
    logic                lit;
    logic [6:0]          seg_next;

    function automatic logic [6:0] seg7_decode(input logic [3:0] n);
        case (n)
            4'h0: seg7_decode = 7'h3F;
            4'h1: seg7_decode = 7'h06;
            4'h2: seg7_decode = 7'h5B;
            4'h3: seg7_decode = 7'h4F;
            4'h4: seg7_decode = 7'h66;
            4'h5: seg7_decode = 7'h6D;
            4'h6: seg7_decode = 7'h7D;
            4'h7: seg7_decode = 7'h07;
            4'h8: seg7_decode = 7'h7F;
            4'h9: seg7_decode = 7'h6F;
            4'hA: seg7_decode = 7'h77;
            4'hB: seg7_decode = 7'h7C;
            4'hC: seg7_decode = 7'h39;
            4'hD: seg7_decode = 7'h5E;
            4'hE: seg7_decode = 7'h79;
            default: seg7_decode = 7'h71;
        endcase
    endfunction

    assign slot_end = (pcnt == PW'(PRESCALE - 1));
    assign wrap     = slot_end && (idx == IW'(DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (slot_end) begin
            pcnt <= '0;
            idx  <= wrap ? '0 : idx + 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // A load landing on the wrap goes straight to the shadow so it shows on the very next digit-0 slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_val  <= '0;
            stage_dp   <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
        end else if (wrap) begin
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
            end else if (pending) begin
                shadow_val <= stage_val;
                shadow_dp  <= stage_dp;
            end
            pending <= 1'b0;
        end else if (load) begin
            stage_val <= value;
            stage_dp  <= dp_in;
            pending   <= 1'b1;
        end
    end

    always_comb begin
        nib    = 4'h0;
        dp_bit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib    = shadow_val[4*i +: 4];
                dp_bit = shadow_dp[i];
            end
        end
    end

    assign win_end = (PW+1)'((32'(brightness) + 32'd1) * 32'(STEP));
    assign lit     = ({1'b0, pcnt} < win_end);

`ifdef SEG7_LZB_EN
    logic [DIGITS-1:0] lead_zero;
    logic              blank;

    // lead_zero[i]: nibbles DIGITS-1 down to i are all zero.
    always_comb begin
        lead_zero             = '0;
        lead_zero[DIGITS-1]   = (shadow_val[4*(DIGITS-1) +: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            lead_zero[i] = lead_zero[i+1] && (shadow_val[4*i +: 4] == 4'h0);
        end
        blank = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                blank = lead_zero[i];
            end
        end
    end

    assign seg_next = (lit && !blank) ? seg7_decode(nib) : 7'h00;
`else
    assign seg_next = lit ? seg7_decode(nib) : 7'h00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            segments   <= '0;
            dp         <= 1'b0;
            digit_sel  <= '0;
            frame_done <= 1'b0;
            wrap_d     <= 1'b0;
        end else begin
            segments   <= seg_next;
            dp         <= lit && dp_bit;
            digit_sel  <= DIGITS'(1) << idx;
            wrap_d     <= wrap;
            frame_done <= wrap_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIGITS=4, PRESCALE=16): stimulus queues cycle-tagged expectations, a negedge monitor checks them.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic [3:0]  brightness;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  digit_sel;
    logic        frame_done;

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .brightness (brightness),
        .segments   (segments),
        .dp         (dp),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SEG7_LZB_EN
    localparam logic [6:0] Z_HI = 7'h00;
`else
    localparam logic [6:0] Z_HI = 7'h3F;
`endif

    typedef struct {
        int         tag;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] sel;
        logic       fd;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc;

    // Posedges since reset release; output cycle n reflects pcnt=(n-1)%16, idx=((n-1)/16)%4.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (e.tag < cyc) begin
                bad++;
                $display("FAIL %s missed: checked at cyc=%0d, required cyc=%0d", e.name, cyc, e.tag);
            end else if (segments !== e.seg || dp !== e.dp || digit_sel !== e.sel || frame_done !== e.fd) begin
                bad++;
                $display("FAIL %s cyc=%0d got seg=%h dp=%b sel=%b fd=%b, want seg=%h dp=%b sel=%b fd=%b",
                         e.name, cyc, segments, dp, digit_sel, frame_done, e.seg, e.dp, e.sel, e.fd);
            end
        end
    end

    task automatic push(input int tag, input logic [6:0] seg, input logic d,
                        input logic [3:0] sel, input logic fd, input string name);
        exp_t e;
        e.tag = tag; e.seg = seg; e.dp = d; e.sel = sel; e.fd = fd; e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int k);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cyc != k && guard < 1000);
        if (cyc != k) begin
            total++;
            bad++;
            $display("FAIL wait_cyc timeout: cyc=%0d, required %0d", cyc, k);
        end
    endtask

    initial begin
        rst        = 1'b1;
        value      = '0;
        dp_in      = '0;
        load       = 1'b0;
        brightness = 4'd15;
        push(0, 7'h00, 1'b0, 4'b0000, 1'b0, "reset_state");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Never loaded: scan of zeros
        push(1,  7'h3F, 1'b0, 4'b0001, 1'b0, "t1_first");
        push(16, 7'h3F, 1'b0, 4'b0001, 1'b0, "t1_slot0_end");
        push(17, Z_HI,  1'b0, 4'b0010, 1'b0, "t1_dig1");
        push(33, Z_HI,  1'b0, 4'b0100, 1'b0, "t1_dig2");
        push(49, Z_HI,  1'b0, 4'b1000, 1'b0, "t1_dig3");
        push(64, Z_HI,  1'b0, 4'b1000, 1'b0, "t1_frame_end");
        push(65, 7'h3F, 1'b0, 4'b0001, 1'b1, "t1_frame_done");
        push(66, 7'h3F, 1'b0, 4'b0001, 1'b0, "t1_fd_one_cycle");

        // Load 12AF mid-frame; shows from the next frame
        push(100, Z_HI,  1'b0, 4'b0100, 1'b0, "t2_old_frame");
        push(128, Z_HI,  1'b0, 4'b1000, 1'b0, "t2_no_tear");
        push(129, 7'h71, 1'b0, 4'b0001, 1'b1, "t2_F");
        push(150, 7'h77, 1'b0, 4'b0010, 1'b0, "t2_A");
        push(161, 7'h5B, 1'b1, 4'b0100, 1'b0, "t2_2_dp");
        push(190, 7'h06, 1'b0, 4'b1000, 1'b0, "t2_1");
        wait_cyc(70);
        value = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
        wait_cyc(71);
        load = 1'b0;

        // Brightness 3 then 0
        wait_cyc(192);
        brightness = 4'd3;
        for (int p = 0; p < 16; p++)
            push(193 + p, (p < 4) ? 7'h71 : 7'h00, 1'b0, 4'b0001, (p == 0), "t3_pwm3");
        push(228, 7'h5B, 1'b1, 4'b0100, 1'b0, "t3_dp_on");
        push(229, 7'h00, 1'b0, 4'b0100, 1'b0, "t3_dp_off");
        wait_cyc(240);
        brightness = 4'd0;
        for (int p = 0; p < 16; p++)
            push(241 + p, (p < 1) ? 7'h06 : 7'h00, 1'b0, 4'b1000, 1'b0, "t3_pwm0");
        wait_cyc(256);
        brightness = 4'd15;

        // Last staged load wins; load on the wrap bypasses staging
        push(320, 7'h06, 1'b0, 4'b1000, 1'b0, "t4_old_kept");
        push(321, 7'h5B, 1'b0, 4'b0001, 1'b1, "t4_last_wins0");
        push(340, 7'h5B, 1'b0, 4'b0010, 1'b0, "t4_last_wins1");
        push(360, 7'h5B, 1'b0, 4'b0100, 1'b0, "t4_last_wins2");
        push(380, 7'h5B, 1'b0, 4'b1000, 1'b0, "t4_last_wins3");
        push(384, 7'h5B, 1'b0, 4'b1000, 1'b0, "t4_pre_bypass");
        push(385, 7'h4F, 1'b0, 4'b0001, 1'b1, "t4_bypass");
        push(449, 7'h4F, 1'b0, 4'b0001, 1'b1, "t4_no_pending");
        wait_cyc(270);
        value = 16'h1111; dp_in = 4'b0000; load = 1'b1;
        wait_cyc(271);
        load = 1'b0;
        wait_cyc(300);
        value = 16'h2222; load = 1'b1;
        wait_cyc(301);
        load = 1'b0;
        wait_cyc(383);
        value = 16'h3333; load = 1'b1;
        wait_cyc(384);
        load = 1'b0;

        // Asynchronous reset mid-slot on digit 2
        wait_cyc(485);
        #2 rst = 1'b1;
        #1;
        total++;
        if (segments !== 7'h00 || dp !== 1'b0 || digit_sel !== 4'b0000 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got seg=%h dp=%b sel=%b fd=%b, want all zero",
                     segments, dp, digit_sel, frame_done);
        end
        push(0,  7'h00, 1'b0, 4'b0000, 1'b0, "t5_held_reset");
        push(1,  7'h3F, 1'b0, 4'b0001, 1'b0, "t5_restart");
        push(17, Z_HI,  1'b0, 4'b0010, 1'b0, "t5_dig1");
        @(negedge clk);
        rst = 1'b0;

        // Leading-zero handling with value 0050, dp on digit 3
        push(65,  7'h3F, 1'b0, 4'b0001, 1'b1, "t6_dig0");
        push(81,  7'h6D, 1'b0, 4'b0010, 1'b0, "t6_dig1");
        push(97,  Z_HI,  1'b0, 4'b0100, 1'b0, "t6_dig2");
        push(113, Z_HI,  1'b1, 4'b1000, 1'b0, "t6_dig3_dp");
        wait_cyc(10);
        value = 16'h0050; dp_in = 4'b1000; load = 1'b1;
        wait_cyc(11);
        load = 1'b0;
        wait_cyc(120);

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s never checked: cyc=%0d, required cyc=%0d", e.name, cyc, e.tag);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
